jtbubl_colmix: RTL

//  Colour mixer downstream of jtbubl_gfx. Converts the 8-bit palette index
//  (col_addr) into 12-bit RGB through a CPU-writable 256x16 palette RAM.

---
 rtl/jtbubl_colmix_if.sv | 20 ++
 rtl/jtbubl_colmix.sv | 113 +++++++++++
 2 files changed

// File: rtl/jtbubl_colmix_if.sv
// jtbubl_colmix_if
//   CPU-side palette bus of the colour mixer.
//   master : CPU (drives strobe/address/data, receives read data)
//   slave  : colour mixer (receives strobe/address/data, drives read data)
// Signals
//   pal_cs    palette chip select
//   cpu_rnw   1 = read, 0 = write
//   cpu_addr  [8:1] palette entry, [0] byte select (0 = {R,G}, 1 = {B,x})
//   cpu_dout  write data from the CPU
//   pal_dout  registered read data back to the CPU
interface jtbubl_colmix_if;
    logic       pal_cs;
    logic       cpu_rnw;
    logic [8:0] cpu_addr;
    logic [7:0] cpu_dout;
    logic [7:0] pal_dout;

    modport master (output pal_cs, cpu_rnw, cpu_addr, cpu_dout, input pal_dout);
    modport slave  (input pal_cs, cpu_rnw, cpu_addr, cpu_dout, output pal_dout);
endinterface

// File: rtl/jtbubl_colmix.sv
// jtbubl_colmix
//   Colour mixer behind jtbubl_gfx: maps the 8-bit palette index to 12-bit RGB
//   through a CPU-writable 256x16 palette (two 256x8 banks) and delays the
//   blanking signals so they line up with the pixel data.
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   pxl_cen_i         pixel clock enable; the video pipeline only moves on it
//   lhbl_i, lvbl_i    blanking inputs, active low, undelayed
//   col_addr_i        palette index, sampled on pxl_cen_i
//   gfx_en_i          debug layer mask (only with JTBUBL_GFX_MASK_EN)
//   cpu               palette bus (jtbubl_colmix_if.slave)
//   red_o/green_o/blue_o  pixel colour, forced to 0 while blanked
//   lhbl_dly_o, lvbl_dly_o  blanking delayed by BLANK_DLY pixels
// Parameters
//   BLANK_DLY  blanking delay in pixels; must match the pixel pipeline (2)
//   SIMFILE    palette preload name for simulation models; unused in this RTL
// Configuration
//   JTBUBL_GFX_MASK_EN  when defined, gfx_en_i = 0 forces the index to 8'hFF
//                       (backdrop entry); when undefined gfx_en_i is ignored.
module jtbubl_colmix #(
    parameter int BLANK_DLY = 2,
    parameter     SIMFILE   = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pxl_cen_i,
    input  logic                  lhbl_i,
    input  logic                  lvbl_i,
    input  logic [7:0]            col_addr_i,
    input  logic                  gfx_en_i,
    jtbubl_colmix_if.slave        cpu,
    output logic [3:0]            red_o,
    output logic [3:0]            green_o,
    output logic [3:0]            blue_o,
    output logic                  lhbl_dly_o,
    output logic                  lvbl_dly_o
);
    // Palette banks: even = {R,G}, odd = {B,x}. Not reset, so the CPU's
    // palette survives a core reset.
    logic [7:0] pal_even [256];
    logic [7:0] pal_odd  [256];

    logic [7:0]           cpu_entry;
    logic                 cpu_we;
    logic                 cpu_re;
    logic [7:0]           vid_idx;

    logic [11:0]          pix_d,  pix_q;
    logic [11:0]          rgb_d,  rgb_q;
    logic [BLANK_DLY-1:0] lhbl_d, lhbl_q;
    logic [BLANK_DLY-1:0] lvbl_d, lvbl_q;
    logic [7:0]           dout_d, dout_q;

    assign cpu_entry = cpu.cpu_addr[8:1];
    assign cpu_we    = cpu.pal_cs & ~cpu.cpu_rnw;
    assign cpu_re    = cpu.pal_cs &  cpu.cpu_rnw;

`ifdef JTBUBL_GFX_MASK_EN
    // Masked layer shows the backdrop colour, decided per pixel.
    assign vid_idx = gfx_en_i ? col_addr_i : 8'hFF;
`else
    logic unused_gfx_en;
    assign unused_gfx_en = gfx_en_i;
    assign vid_idx       = col_addr_i;
`endif

    // CPU write port. The video/CPU read registers sample the arrays on the
    // same edge through non-blocking updates, so a colliding read sees the
    // old entry (read-first).
    always_ff @(posedge clk) begin
        if (cpu_we) begin
            if (cpu.cpu_addr[0]) pal_odd[cpu_entry]  <= cpu.cpu_dout;
            else                 pal_even[cpu_entry] <= cpu.cpu_dout;
        end
    end

    always_comb begin
        // S0/S1: index sampled and both bytes fetched in one registered read.
        // The low nibble of the odd byte never reaches video.
        pix_d  = {pal_even[vid_idx], pal_odd[vid_idx][7:4]};
        // S2: the blank bits travelling with pix_q are one stage behind the
        // delay-line input, i.e. the bits that become lhbl/lvbl_dly on this edge.
        rgb_d  = (lhbl_q[BLANK_DLY-2] & lvbl_q[BLANK_DLY-2]) ? pix_q : 12'h000;
        lhbl_d = {lhbl_q[BLANK_DLY-2:0], lhbl_i};
        lvbl_d = {lvbl_q[BLANK_DLY-2:0], lvbl_i};
        dout_d = cpu.cpu_addr[0] ? pal_odd[cpu_entry] : pal_even[cpu_entry];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q  <= '0;
            rgb_q  <= '0;
            lhbl_q <= '0;
            lvbl_q <= '0;
            dout_q <= '0;
        end else begin
            if (pxl_cen_i) begin
                pix_q  <= pix_d;
                rgb_q  <= rgb_d;
                lhbl_q <= lhbl_d;
                lvbl_q <= lvbl_d;
            end
            if (cpu_re) dout_q <= dout_d;
        end
    end

    assign cpu.pal_dout = dout_q;
    assign red_o        = rgb_q[11:8];
    assign green_o      = rgb_q[7:4];
    assign blue_o       = rgb_q[3:0];
    assign lhbl_dly_o   = lhbl_q[BLANK_DLY-1];
    assign lvbl_dly_o   = lvbl_q[BLANK_DLY-1];
endmodule
